// File: rtl/eda_window_scanner.sv
// rtl/eda_window_scanner.sv - raster-order 3x3 window sequencer with bordered valid/ready output
module eda_window_scanner #(
    parameter int M            = 16,
    parameter int N            = 16,
    parameter int PIXEL_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 9,
    parameter int ADDR_WIDTH   = $clog2(M*N)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [ADDR_WIDTH-1:0]               center_addr,
    input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
    output logic                                win_valid,
    input  logic                                win_ready,
    output logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] win_data,
    output logic [WINDOW_WIDTH-1:0]             win_mask,
    output logic [ADDR_WIDTH-1:0]               win_addr,
    output logic                                win_last
);

    localparam int ROW_W = $clog2(N);
    localparam int COL_W = $clog2(M);
    localparam logic [ROW_W-1:0]      ROW_MAX   = ROW_W'(N-1);
    localparam logic [COL_W-1:0]      COL_MAX   = COL_W'(M-1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(M*N-1);

    typedef enum logic [1:0] {IDLE, SCAN, LAST} state_t;

    state_t                              state;
    logic [ROW_W-1:0]                    row;
    logic [COL_W-1:0]                    col;
    logic [ADDR_WIDTH-1:0]               addr;
    logic [WINDOW_WIDTH-1:0]             mask;
    logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] masked;
    logic                                load;

    // Running address tracks row*M+col so no multiplier is needed.
    assign center_addr = addr;
    assign load        = !win_valid || win_ready;

    always_comb begin
        mask = '1;
        if (row == '0) begin
            mask[8] = 1'b0; mask[7] = 1'b0; mask[6] = 1'b0;
        end
        if (row == ROW_MAX) begin
            mask[2] = 1'b0; mask[1] = 1'b0; mask[0] = 1'b0;
        end
        if (col == '0) begin
            mask[8] = 1'b0; mask[5] = 1'b0; mask[2] = 1'b0;
        end
        if (col == COL_MAX) begin
            mask[6] = 1'b0; mask[3] = 1'b0; mask[0] = 1'b0;
        end
    end

    always_comb begin
        masked = '0;
        for (int i = 0; i < WINDOW_WIDTH; i++) begin
            if (mask[i]) masked[i*PIXEL_WIDTH +: PIXEL_WIDTH] = window_values[i*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            addr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_data  <= '0;
            win_mask  <= '0;
            win_addr  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (load) begin
                        win_valid <= 1'b1;
                        win_data  <= masked;
                        win_mask  <= mask;
                        win_addr  <= addr;
                        if (addr == LAST_ADDR) begin
                            win_last <= 1'b1;
                            state    <= LAST;
                        end else begin
                            addr <= addr + 1'b1;
                            if (col == COL_MAX) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                LAST: begin
                    if (win_valid && win_ready) begin
                        win_valid <= 1'b0;
                        win_last  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                        row       <= '0;
                        col       <= '0;
                        addr      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eda_window_scanner.sv
// tb/tb_eda_window_scanner.sv - randomized self-checking bench for eda_window_scanner
module tb_eda_window_scanner;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int PW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] center_addr;
    logic [71:0]   window_values;
    logic          win_valid;
    logic          win_ready;
    logic [71:0]   win_data;
    logic [8:0]    win_mask;
    logic [AW-1:0] win_addr;
    logic          win_last;

    eda_window_scanner #(.M(M), .N(N), .PIXEL_WIDTH(PW), .WINDOW_WIDTH(9), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .center_addr(center_addr), .window_values(window_values),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_mask(win_mask), .win_addr(win_addr), .win_last(win_last)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0] img [M*N];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Window RAM: in-bounds lanes from the image, out-of-bounds lanes hold junk the DUT must mask.
    always_comb begin
        int r, c, k, rr, cc;
        window_values = '0;
        r = int'(center_addr) / M;
        c = int'(center_addr) % M;
        for (int l = 0; l < 9; l++) begin
            k  = 8 - l;
            rr = r + k / 3 - 1;
            cc = c + k % 3 - 1;
            if (rr >= 0 && rr < N && cc >= 0 && cc < M)
                window_values[l*PW +: PW] = img[rr*M + cc];
            else
                window_values[l*PW +: PW] = 8'hC0 + 8'(l);
        end
    end

    function automatic void exp_win(input int a, output logic [71:0] d, output logic [8:0] m);
        int r, c, k, rr, cc;
        r = a / M;
        c = a % M;
        d = '0;
        m = '0;
        for (int l = 0; l < 9; l++) begin
            k  = 8 - l;
            rr = r + k / 3 - 1;
            cc = c + k % 3 - 1;
            if (rr >= 0 && rr < N && cc >= 0 && cc < M) begin
                m[l] = 1'b1;
                d[l*PW +: PW] = img[rr*M + cc];
            end
        end
    endfunction

    int          cyc = 0, beats = 0, dones = 0, exp_idx = 0;
    int          first_cyc = 0, last_cyc = 0, done_cyc = 0;
    bit          prev_final = 0, stall = 0;
    logic [71:0] s_data;
    logic [8:0]  s_mask;
    logic [AW-1:0] s_addr;
    logic        s_last;
    logic [71:0] cap_data [M*N];
    logic [8:0]  cap_mask [M*N];
    logic        cap_last [M*N];

    always @(negedge clk) begin
        logic [71:0] ed;
        logic [8:0]  em;
        cyc++;
        if (!reset_n) begin
            exp_idx    = 0;
            prev_final = 0;
            stall      = 0;
            chk("rst_valid", win_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
        end else begin
            chk("done_pulse", done, prev_final);
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (stall) begin
                chk("stall_valid", win_valid, 1'b1);
                chk("stall_data", win_data, s_data);
                chk("stall_mask", win_mask, s_mask);
                chk("stall_addr", win_addr, s_addr);
                chk("stall_last", win_last, s_last);
            end
            prev_final = 0;
            if (win_valid && win_ready) begin
                exp_win(exp_idx, ed, em);
                chk("beat_addr", win_addr, exp_idx);
                chk("beat_data", win_data, ed);
                chk("beat_mask", win_mask, em);
                chk("beat_last", win_last, exp_idx == M*N-1);
                cap_data[win_addr] = win_data;
                cap_mask[win_addr] = win_mask;
                cap_last[win_addr] = win_last;
                if (exp_idx == 0) first_cyc = cyc;
                beats++;
                if (exp_idx == M*N-1) begin
                    prev_final = 1;
                    last_cyc   = cyc;
                    exp_idx    = 0;
                end else begin
                    exp_idx++;
                end
            end
            stall  = win_valid && !win_ready;
            s_data = win_data;
            s_mask = win_mask;
            s_addr = win_addr;
            s_last = win_last;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input bit rnd, input int limit);
        int n = 0;
        while (dones < target && n < limit) begin
            tick();
            if (rnd) win_ready = 1'($urandom_range(0, 1));
            n++;
        end
        chk("done_timeout", dones >= target, 1'b1);
        win_ready = 1'b1;
    endtask

    task automatic wait_beats(input int target, input int limit);
        int n = 0;
        while (beats < target && n < limit) begin
            tick();
            n++;
        end
        chk("beat_timeout", beats >= target, 1'b1);
    endtask

    initial begin
        int b0, d0, n;
        reset_n   = 1'b0;
        start     = 1'b0;
        win_ready = 1'b0;
        for (int a = 0; a < M*N; a++) img[a] = 8'(a);
        repeat (3) tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_valid", win_valid, 1'b0);
        chk("reset_last", win_last, 1'b0);
        chk("reset_data", win_data, 72'h0);
        chk("reset_mask", win_mask, 9'h0);
        chk("reset_addr", win_addr, 4'h0);
        chk("reset_center", center_addr, 4'h0);
        reset_n = 1'b1;
        tick();

        // Directed scan: pixel[a]=a, always ready.
        win_ready = 1'b1;
        b0 = beats; d0 = dones;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_busy", busy, 1'b1);
        chk("lat_valid_early", win_valid, 1'b0);
        tick();
        chk("lat_valid", win_valid, 1'b1);
        chk("lat_addr0", win_addr, 4'h0);
        wait_done(d0 + 1, 1'b0, 100);
        chk("dir_beats", beats - b0, 16);
        chk("dir_consec", last_cyc - first_cyc, 15);
        chk("dir_done_lat", done_cyc - last_cyc, 1);
        chk("dir_busy_end", busy, 1'b0);
        chk("a0_mask", cap_mask[0], 9'h01B);
        chk("a0_data", cap_data[0], 72'h00_00_00_00_00_01_00_04_05);
        chk("a5_mask", cap_mask[5], 9'h1FF);
        chk("a5_data", cap_data[5], 72'h00_01_02_04_05_06_08_09_0A);
        chk("a15_mask", cap_mask[15], 9'h1B0);
        chk("a15_last", cap_last[15], 1'b1);
        chk("a15_data", cap_data[15], 72'h0A_0B_00_0E_0F_00_00_00_00);
        chk("a3_mask", cap_mask[3], 9'h036);
        chk("a3_last", cap_last[3], 1'b0);
        tick();

        // Random images with random backpressure.
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < M*N; a++) img[a] = 8'($urandom);
            b0 = beats; d0 = dones;
            win_ready = 1'($urandom_range(0, 1));
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_done(d0 + 1, 1'b1, 1000);
            chk("rnd_beats", beats - b0, 16);
            repeat (2) tick();
        end

        // start while busy is ignored.
        for (int a = 0; a < M*N; a++) img[a] = 8'(a * 3);
        b0 = beats; d0 = dones;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_beats(b0 + 7, 100);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(d0 + 1, 1'b0, 100);
        chk("busy_start_beats", beats - b0, 16);
        repeat (4) tick();
        chk("busy_start_dones", dones - d0, 1);
        chk("busy_start_idle", busy, 1'b0);

        // start coincident with done launches a second scan.
        b0 = beats; d0 = dones;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("done_seen", done, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(d0 + 2, 1'b0, 100);
        chk("back2back_beats", beats - b0, 32);
        tick();

        // Reset mid-scan, then restart from address 0.
        b0 = beats; d0 = dones;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_beats(b0 + 9, 100);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", win_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_center", center_addr, 4'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("midrst_no_done", dones - d0, 0);
        b0 = beats;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(d0 + 1, 1'b1, 1000);
        chk("restart_beats", beats - b0, 16);
        chk("restart_first", cap_mask[0], 9'h01B);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
